// File: rtl/dff_bank_write_arbiter_if.sv
// dff_bank_write_arbiter_if: request/write bus between requesters and the register-bank write arbiter
interface dff_bank_write_arbiter_if #(
    parameter int N_REQ    = 4,
    parameter int NUM_REGS = 6,
    parameter int ADDR_W   = 3,
    parameter int WIDTH    = 8
) ();
    localparam int PTR_W = $clog2(N_REQ);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*WIDTH-1:0]  req_data;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        err;
    logic [NUM_REGS-1:0]     wr_en;
    logic [WIDTH-1:0]        wr_data;
    logic [PTR_W-1:0]        grant_id;
    logic                    busy;
    modport master (output req, req_addr, req_data,
                    input  ack, err, wr_en, wr_data, grant_id, busy);
    modport slave  (input  req, req_addr, req_data,
                    output ack, err, wr_en, wr_data, grant_id, busy);
endinterface

// File: rtl/dff_bank_write_arbiter.sv
// dff_bank_write_arbiter: round-robin arbiter issuing one registered write per cycle to a DFF register bank
module dff_bank_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int NUM_REGS = 6,
    parameter int ADDR_W   = 3,
    parameter int WIDTH    = 8
) (
    input logic                    clk,
    input logic                    rst,
    dff_bank_write_arbiter_if.slave arb_if
);
    localparam int PTR_W = $clog2(N_REQ);
    logic [N_REQ-1:0]    ack_q, ack_d, err_q, err_d, elig;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [PTR_W-1:0]    grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, win;
    logic                busy_q, busy_d, found, legal;
    logic [ADDR_W-1:0]   win_addr;
    int                  idx;
    // Pick the first eligible requester from rr_ptr onward; the one just served is masked for a cycle
    always_comb begin
        elig  = arb_if.req & ~(ack_q | err_q);
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            idx = (idx >= N_REQ) ? idx - N_REQ : idx;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        win_addr   = arb_if.req_addr[win*ADDR_W +: ADDR_W];
        legal      = int'(win_addr) < NUM_REGS;
        ack_d      = (found && legal)  ? N_REQ'(1) << win : '0;
        err_d      = (found && !legal) ? N_REQ'(1) << win : '0;
        wr_en_d    = (found && legal)  ? NUM_REGS'(1) << win_addr : '0;
        wr_data_d  = (found && legal)  ? arb_if.req_data[win*WIDTH +: WIDTH] : wr_data_q;
        grant_id_d = found ? win : grant_id_q;
        busy_d     = found;
        rr_ptr_d   = found ? ((win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1)) : rr_ptr_q;
    end
    // Register all outputs and the round-robin pointer; reset discards any grant sampled on that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q      <= '0;
            err_q      <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end
    assign arb_if.ack      = ack_q;
    assign arb_if.err      = err_q;
    assign arb_if.wr_en    = wr_en_q;
    assign arb_if.wr_data  = wr_data_q;
    assign arb_if.grant_id = grant_id_q;
    assign arb_if.busy     = busy_q;
endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// tb_dff_bank_write_arbiter: directed stimulus checked against a behavioural arbiter model every cycle
module tb_dff_bank_write_arbiter;
    localparam int N = 4;
    localparam int NR = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    bit live = 1'b0;
    logic [2:0] addr [N];
    logic [7:0] data [N];
    logic [N-1:0] exp_ack = '0, exp_err = '0;
    logic [NR-1:0] exp_wr_en = '0;
    logic [7:0] exp_wr_data = '0;
    int exp_grant = 0, m_ptr = 0;
    bit exp_busy = 1'b0;

    dff_bank_write_arbiter_if #(.N_REQ(N), .NUM_REGS(NR), .ADDR_W(3), .WIDTH(8)) arb_if ();
    dff_bank_write_arbiter #(.N_REQ(N), .NUM_REGS(NR), .ADDR_W(3), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .arb_if(arb_if.slave));

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            arb_if.req_addr[i*3 +: 3] = addr[i];
            arb_if.req_data[i*8 +: 8] = data[i];
        end
    end

    function automatic int pick(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++)
            if (e[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // Behavioural model: served requester is remembered and skipped once, pointer follows the winner
    always @(posedge clk) begin
        logic [N-1:0] e;
        int w;
        live = 1'b1;
        if (rst) begin
            exp_ack = '0; exp_err = '0; exp_wr_en = '0; exp_wr_data = '0;
            exp_grant = 0; exp_busy = 0; m_ptr = 0;
        end else begin
            e = arb_if.req & ~(exp_ack | exp_err);
            w = pick(e, m_ptr);
            exp_ack = '0; exp_err = '0; exp_wr_en = '0;
            exp_busy = (w >= 0);
            if (w >= 0) begin
                exp_grant = w;
                m_ptr = (w + 1) % N;
                if (int'(addr[w]) < NR) begin
                    exp_ack[w] = 1'b1;
                    exp_wr_en[addr[w]] = 1'b1;
                    exp_wr_data = data[w];
                end else exp_err[w] = 1'b1;
            end
        end
    end

    // Compare DUT against model every cycle on the falling edge
    always @(negedge clk) begin
        if (live) begin
            cmp("ack", 32'(arb_if.ack), 32'(exp_ack));
            cmp("err", 32'(arb_if.err), 32'(exp_err));
            cmp("wr_en", 32'(arb_if.wr_en), 32'(exp_wr_en));
            cmp("wr_data", 32'(arb_if.wr_data), 32'(exp_wr_data));
            cmp("busy", 32'(arb_if.busy), 32'(exp_busy));
            if (exp_busy) cmp("grant_id", 32'(arb_if.grant_id), 32'(exp_grant));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [N-1:0] pats [10] = '{4'b0011, 4'b0110, 4'b1111, 4'b1001, 4'b0000,
                                    4'b1100, 4'b0101, 4'b1111, 4'b1010, 4'b0001};
        for (int i = 0; i < N; i++) begin
            addr[i] = 3'(i + 1);
            data[i] = 8'(8'h10 * (i + 1) + i);
        end
        arb_if.req = 4'b1111;
        tick();
        cmp("rst_busy", 32'(arb_if.busy), 32'd0);
        cmp("rst_grant", 32'(arb_if.grant_id), 32'd0);
        tick();
        cmp("rst_ack", 32'(arb_if.ack), 32'd0);
        cmp("rst_wr_en", 32'(arb_if.wr_en), 32'd0);
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            tick();
            cmp("rr_order", 32'(arb_if.grant_id), 32'(g % N));
            cmp("rr_ack", 32'(arb_if.ack), 32'(1 << (g % N)));
        end
        arb_if.req = '0;
        tick();
        addr[0] = 3'd2; data[0] = 8'hA5; arb_if.req = 4'b0001;
        tick();
        cmp("single_wr_en", 32'(arb_if.wr_en), 32'b000100);
        cmp("single_wr_data", 32'(arb_if.wr_data), 32'hA5);
        cmp("single_ack", 32'(arb_if.ack), 32'b0001);
        tick();
        cmp("single_masked", 32'(arb_if.busy), 32'd0);
        tick();
        cmp("single_again", 32'(arb_if.ack), 32'b0001);
        arb_if.req = '0;
        tick();
        cmp("idle_hold_data", 32'(arb_if.wr_data), 32'hA5);
        addr[2] = 3'd7; arb_if.req = 4'b0100;
        tick();
        cmp("bad_err", 32'(arb_if.err), 32'b0100);
        cmp("bad_wr_en", 32'(arb_if.wr_en), 32'd0);
        cmp("bad_ack", 32'(arb_if.ack), 32'd0);
        arb_if.req = '0;
        tick();
        addr[2] = 3'd5; arb_if.req = 4'b1111;
        tick();
        cmp("ptr_after_err", 32'(arb_if.grant_id), 32'd3);
        tick();
        arb_if.req = 4'b0010;
        tick();
        cmp("grant1", 32'(arb_if.ack), 32'b0010);
        arb_if.req = 4'b1010;
        tick();
        cmp("skip_served", 32'(arb_if.grant_id), 32'd3);
        arb_if.req = '0;
        tick();
        arb_if.req = 4'b0010; rst = 1'b1;
        tick();
        cmp("midrst_ack", 32'(arb_if.ack), 32'd0);
        cmp("midrst_wr_en", 32'(arb_if.wr_en), 32'd0);
        rst = 1'b0;
        tick();
        cmp("post_rst_ack", 32'(arb_if.ack), 32'b0010);
        arb_if.req = '0;
        tick();
        foreach (pats[p]) begin
            arb_if.req = pats[p];
            tick();
        end
        arb_if.req = '0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
